// File: rtl/md_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: decodes the MD class,
// drives the unit, shadows its busy window and stalls colliding MD instructions.
//
// state | meaning
// IDLE  | no operation tracked; MD instructions may issue if the unit is not busy
// COUNT | shadow counter running down the unit's fixed busy window
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_cls,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    output logic [31:0] mdu_a,
    output logic [31:0] mdu_b,
    output logic        mdu_rdsel,
    output logic        stall,
    output logic        sync_err,
    output logic [31:0] stall_cycles
);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               prev_idle;

    logic is_md;
    logic is_arith;
    logic is_div;
    logic issue;

    always_comb begin
        is_md    = e_valid && (e_md_cls >= 4'd1) && (e_md_cls <= 4'd8);
        is_arith = (e_md_cls >= 4'd1) && (e_md_cls <= 4'd4);
        is_div   = (e_md_cls == 4'd3) || (e_md_cls == 4'd4);
        stall    = is_md && !flush && ((state == COUNT) || mdu_busy);
        issue    = is_md && !flush && !stall && !reset;
    end

    always_comb begin
        mdu_start = issue && is_arith;
        mdu_op    = 3'd0;
        if (issue && (e_md_cls <= 4'd6))
            mdu_op = e_md_cls[2:0];
        mdu_a     = e_rs;
        mdu_b     = e_rt;
        mdu_rdsel = e_valid && (e_md_cls == 4'd8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            prev_idle    <= 1'b0;
            sync_err     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            prev_idle <= (state == IDLE);
            // Busy seen in a second consecutive IDLE cycle means the unit's
            // window outlasted the shadow counter.
            if ((state == IDLE) && mdu_busy && prev_idle)
                sync_err <= 1'b1;
            if (stall)
                stall_cycles <= stall_cycles + 32'd1;
            case (state)
                IDLE: begin
                    if (issue && is_arith) begin
                        cnt   <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus random traffic against a
// cycle-number based model of the controller window and a behavioural MD unit.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_cls;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        flush;
    logic        mdu_busy;
    logic        mdu_start;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_rdsel;
    logic        stall;
    logic        sync_err;
    logic [31:0] stall_cycles;

    md_issue_ctrl dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_cls(e_md_cls),
        .e_rs(e_rs), .e_rt(e_rt), .flush(flush), .mdu_busy(mdu_busy),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_a(mdu_a), .mdu_b(mdu_b),
        .mdu_rdsel(mdu_rdsel), .stall(stall), .sync_err(sync_err),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: absolute cycle numbers instead of counters.
    int          cyc         = 0;
    int          ctrl_issue  = -1000;
    int          ctrl_n      = 0;
    int          unit_start  = -1000;
    int          unit_len    = 0;
    int          busy_ext    = 0;
    bit          m_prev_idle = 0;
    bit          m_sync      = 0;
    logic [31:0] m_stall_cnt = 0;

    bit          m_count, m_md, m_stall, m_issue, m_rst;
    logic        exp_start, exp_rdsel;
    logic [2:0]  exp_op;
    logic [3:0]  cur_cls;

    task automatic set_in(input bit v, input logic [3:0] cls, input logic [31:0] rs,
                          input logic [31:0] rt, input bit fl, input bit rst);
        e_valid  = v;
        e_md_cls = cls;
        e_rs     = rs;
        e_rt     = rt;
        flush    = fl;
        reset    = rst;
        mdu_busy = (cyc > unit_start) && (cyc <= unit_start + unit_len);
        cur_cls  = cls;
        m_rst    = rst;
        m_count  = (cyc > ctrl_issue) && (cyc <= ctrl_issue + ctrl_n);
        m_md     = v && (cls >= 1) && (cls <= 8);
        m_stall  = m_md && !fl && (m_count || mdu_busy);
        m_issue  = m_md && !fl && !m_stall && !rst;
        exp_start = m_issue && (cls <= 4);
        exp_op    = (m_issue && cls <= 6) ? cls[2:0] : 3'd0;
        exp_rdsel = (cls == 4'd8);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_rst) begin
            ctrl_issue  = -1000;
            unit_start  = -1000;
            m_stall_cnt = 0;
            m_sync      = 0;
            m_prev_idle = 0;
        end else begin
            if (m_stall) m_stall_cnt = m_stall_cnt + 1;
            if (!m_count && mdu_busy && m_prev_idle) m_sync = 1;
            m_prev_idle = !m_count;
            if (exp_start) begin
                ctrl_issue = cyc;
                ctrl_n     = (cur_cls >= 3) ? 10 : 5;
                unit_start = cyc;
                unit_len   = ctrl_n + busy_ext;
            end
        end
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        set_in(0, 0, 32'h1234_5678, 32'h9abc_def0, 0, 0);
        n_checks++; if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles got %0d want 0", stall_cycles); end
        n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
        n_checks++; if ({mdu_start, mdu_op, stall, mdu_rdsel} !== 6'd0) begin n_fail++; $display("FAIL reset_outputs got start=%b op=%0d stall=%b rdsel=%b want all 0", mdu_start, mdu_op, stall, mdu_rdsel); end
        n_checks++; if (mdu_a !== 32'h1234_5678 || mdu_b !== 32'h9abc_def0) begin n_fail++; $display("FAIL reset_passthrough got a=%h b=%h", mdu_a, mdu_b); end
        n_checks++; if (dut.cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", dut.cnt); end
    endtask

    task automatic test_first_mult();
        do_reset();
        set_in(1, 1, 32'd3, -32'sd2, 0, 0);
        n_checks++; if (mdu_start !== 1'b1 || mdu_op !== 3'd1 || stall !== 1'b0) begin n_fail++; $display("FAIL first_mult_issue got start=%b op=%0d stall=%b want 1 1 0", mdu_start, mdu_op, stall); end
        n_checks++; if (mdu_a !== 32'd3 || mdu_b !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL first_mult_operands got a=%h b=%h want 3 fffffffe", mdu_a, mdu_b); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_checks++; if (dut.cnt !== 4'd5) begin n_fail++; $display("FAIL first_mult_cnt got %0d want 5", dut.cnt); end
    endtask

    task automatic test_mult_mfhi();
        int stalls = 0;
        bit done = 0;
        do_reset();
        set_in(1, 1, 32'd7, 32'd9, 0, 0);
        tick();
        for (int i = 0; i < 20 && !done; i++) begin
            set_in(1, 8, 0, 0, 0, 0);
            if (stall) begin
                stalls++;
                tick();
            end else begin
                done = 1;
                n_checks++; if (stalls !== 5) begin n_fail++; $display("FAIL mult_mfhi_stall_len got %0d want 5", stalls); end
                n_checks++; if (mdu_op !== 3'd0 || mdu_rdsel !== 1'b1 || mdu_start !== 1'b0) begin n_fail++; $display("FAIL mult_mfhi_issue got op=%0d rdsel=%b start=%b want 0 1 0", mdu_op, mdu_rdsel, mdu_start); end
                n_checks++; if (stall_cycles !== 32'd5) begin n_fail++; $display("FAIL mult_mfhi_stall_cycles got %0d want 5", stall_cycles); end
                tick();
            end
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL mult_mfhi_timeout got stalls=%0d want release", stalls); end
    endtask

    task automatic test_divu_mtlo();
        int stalls = 0;
        bit done = 0;
        do_reset();
        set_in(1, 4, 32'd100, 32'd7, 0, 0);
        tick();
        for (int i = 0; i < 30 && !done; i++) begin
            set_in(1, 5, 32'hAA, 0, 0, 0);
            if (stall) begin
                stalls++;
                tick();
            end else begin
                done = 1;
                n_checks++; if (stalls !== 10) begin n_fail++; $display("FAIL divu_mtlo_stall_len got %0d want 10", stalls); end
                n_checks++; if (mdu_op !== 3'd5 || mdu_start !== 1'b0) begin n_fail++; $display("FAIL divu_mtlo_issue got op=%0d start=%b want 5 0", mdu_op, mdu_start); end
                n_checks++; if (stall_cycles !== 32'd10) begin n_fail++; $display("FAIL divu_mtlo_stall_cycles got %0d want 10", stall_cycles); end
                tick();
                set_in(0, 5, 0, 0, 0, 0);
                n_checks++; if (mdu_op !== 3'd0) begin n_fail++; $display("FAIL divu_mtlo_once got op=%0d want 0", mdu_op); end
                tick();
            end
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL divu_mtlo_timeout got stalls=%0d want release", stalls); end
    endtask

    task automatic test_nonmd_flush();
        do_reset();
        set_in(1, 1, 1, 2, 0, 0);
        tick();
        set_in(1, 0, 5, 6, 0, 0);
        n_checks++; if (stall !== 1'b0 || mdu_start !== 1'b0) begin n_fail++; $display("FAIL nonmd_in_count got stall=%b start=%b want 0 0", stall, mdu_start); end
        tick();
        set_in(1, 3, 5, 6, 1, 0);
        n_checks++; if (stall !== 1'b0 || mdu_start !== 1'b0 || mdu_op !== 3'd0) begin n_fail++; $display("FAIL flush_div got stall=%b start=%b op=%0d want 0 0 0", stall, mdu_start, mdu_op); end
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        n_checks++; if (dut.cnt !== 4'd3) begin n_fail++; $display("FAIL flush_cnt got %0d want 3", dut.cnt); end
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_busy_extend();
        int stalls = 0;
        bit done = 0;
        do_reset();
        busy_ext = 2;
        set_in(1, 2, 0, 0, 0, 0);
        tick();
        busy_ext = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            set_in(1, 8, 0, 0, 0, 0);
            if (stall) begin
                n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL busy_ext_early_sync stall=%0d got %b want 0", stalls, sync_err); end
                stalls++;
                tick();
            end else begin
                done = 1;
                n_checks++; if (stalls !== 7) begin n_fail++; $display("FAIL busy_ext_stall_len got %0d want 7", stalls); end
                n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL busy_ext_sync_set got %b want 1", sync_err); end
            end
        end
        if (!done) begin n_checks++; n_fail++; $display("FAIL busy_ext_timeout got stalls=%0d want release", stalls); end
        tick();
        for (int i = 0; i < 12; i++) begin set_in(1, 1, 0, 0, 0, 0); tick(); end
        set_in(0, 0, 0, 0, 0, 0);
        n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL busy_ext_sync_sticky got %b want 1", sync_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(1, 3, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 6; i++) begin set_in(1, 7, 0, 0, 0, 0); tick(); end
        set_in(0, 0, 0, 0, 0, 0);
        n_checks++; if (dut.cnt !== 4'd4 || stall_cycles !== 32'd6) begin n_fail++; $display("FAIL reset_mid_pre got cnt=%0d stall_cycles=%0d want 4 6", dut.cnt, stall_cycles); end
        set_in(0, 0, 0, 0, 0, 1);
        tick();
        set_in(1, 1, 0, 0, 0, 0);
        n_checks++; if (stall !== 1'b0 || mdu_start !== 1'b1 || dut.cnt !== 4'd0) begin n_fail++; $display("FAIL reset_mid_issue got stall=%b start=%b cnt=%0d want 0 1 0", stall, mdu_start, dut.cnt); end
        n_checks++; if (stall_cycles !== 32'd0 || sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_regs got stall_cycles=%0d sync=%b want 0 0", stall_cycles, sync_err); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bit          v  = ($urandom_range(0, 9) != 0);
            logic [3:0]  c  = 4'($urandom_range(0, 15));
            bit          fl = ($urandom_range(0, 9) == 0);
            bit          rs = ($urandom_range(0, 49) == 0);
            logic [31:0] a  = $urandom;
            logic [31:0] b  = $urandom;
            busy_ext = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            set_in(v, c, a, b, fl, rs);
            n_checks++; if (stall !== m_stall) begin n_fail++; $display("FAIL rand_stall cyc=%0d got %b want %b", cyc, stall, m_stall); end
            n_checks++; if (mdu_start !== exp_start || mdu_op !== exp_op) begin n_fail++; $display("FAIL rand_issue cyc=%0d got start=%b op=%0d want %b %0d", cyc, mdu_start, mdu_op, exp_start, exp_op); end
            n_checks++; if (mdu_a !== a || mdu_b !== b) begin n_fail++; $display("FAIL rand_pass cyc=%0d got %h %h want %h %h", cyc, mdu_a, mdu_b, a, b); end
            if (v) begin
                n_checks++; if (mdu_rdsel !== exp_rdsel) begin n_fail++; $display("FAIL rand_rdsel cyc=%0d got %b want %b", cyc, mdu_rdsel, exp_rdsel); end
            end
            n_checks++; if (sync_err !== m_sync || stall_cycles !== m_stall_cnt) begin n_fail++; $display("FAIL rand_regs cyc=%0d got sync=%b cnt=%0d want %b %0d", cyc, sync_err, stall_cycles, m_sync, m_stall_cnt); end
            tick();
        end
        busy_ext = 0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 1);
        @(negedge clk);
        test_reset();
        test_first_mult();
        test_mult_mfhi();
        test_divu_mtlo();
        test_nonmd_flush();
        test_busy_extend();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
